// File: rtl/pwm_rgbw_gen.sv
// Four-channel 8-bit PWM generator (R, G, B, W) advanced by rising edges of a prescaled clock level.
// New duties are staged as pending and only become active at a period boundary, or at once while disabled.
module pwm_rgbw_gen (
    input  logic       clk,
    input  logic       reset,
    input  logic       clkPresc,
    input  logic       enable,
    input  logic       load,
    input  logic [7:0] dutyR,
    input  logic [7:0] dutyG,
    input  logic [7:0] dutyB,
    input  logic [7:0] dutyW,
    output logic       pwmR,
    output logic       pwmG,
    output logic       pwmB,
    output logic       pwmW,
    output logic       loadAck,
    output logic       periodEnd
);

    logic            presc_q;
    logic            presc_d;
    logic [7:0]      cnt_q;
    logic [7:0]      cnt_d;
    logic [3:0][7:0] pend_q;
    logic [3:0][7:0] pend_d;
    logic            pend_flag_q;
    logic            pend_flag_d;
    logic [3:0][7:0] act_q;
    logic [3:0][7:0] act_d;
    logic [3:0]      pwm_q;
    logic [3:0]      pwm_d;
    logic            ack_q;
    logic            ack_d;
    logic            pe_q;
    logic            pe_d;

    logic            tick_s;
    logic            wrap_s;
    logic            apply_s;

    // Next-state logic: prescaler edge detect, period counter, duty staging and PWM compare.
    always_comb begin
        presc_d     = clkPresc;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        pend_flag_d = pend_flag_q;
        act_d       = act_q;
        pwm_d       = 4'b0000;
        ack_d       = 1'b0;
        pe_d        = 1'b0;

        tick_s  = clkPresc & ~presc_q;
        wrap_s  = tick_s & enable & (cnt_q == 8'd255);
        // While disabled there is no period to protect, so pending duties apply immediately.
        apply_s = pend_flag_q & (wrap_s | ~enable);

        if (!enable) begin
            cnt_d = 8'd0;
        end else if (tick_s) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end

        if (apply_s) begin
            act_d = pend_q;
        end else begin
            act_d = act_q;
        end

        // A load on an apply edge re-arms the flag with the new values after the old ones go active.
        if (load) begin
            pend_d      = {dutyW, dutyB, dutyG, dutyR};
            pend_flag_d = 1'b1;
        end else if (apply_s) begin
            pend_flag_d = 1'b0;
        end else begin
            pend_flag_d = pend_flag_q;
        end

        for (int i = 0; i < 4; i++) begin
            pwm_d[i] = enable & (cnt_q < act_q[i]);
        end

        ack_d = apply_s;
        pe_d  = wrap_s;
    end

    // State registers with synchronous reset taking priority over all other inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q     <= 1'b0;
            cnt_q       <= 8'd0;
            pend_q      <= '0;
            pend_flag_q <= 1'b0;
            act_q       <= '0;
            pwm_q       <= 4'b0000;
            ack_q       <= 1'b0;
            pe_q        <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            pend_flag_q <= pend_flag_d;
            act_q       <= act_d;
            pwm_q       <= pwm_d;
            ack_q       <= ack_d;
            pe_q        <= pe_d;
        end
    end

    assign pwmR      = pwm_q[0];
    assign pwmG      = pwm_q[1];
    assign pwmB      = pwm_q[2];
    assign pwmW      = pwm_q[3];
    assign loadAck   = ack_q;
    assign periodEnd = pe_q;

endmodule

// File: tb/tb_pwm_rgbw_gen.sv
// Self-checking bench for pwm_rgbw_gen: per-cycle reference model plus per-period duty measurements.
module tb_pwm_rgbw_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       clkPresc;
    logic       enable;
    logic       load;
    logic [7:0] dutyR;
    logic [7:0] dutyG;
    logic [7:0] dutyB;
    logic [7:0] dutyW;
    logic       pwmR;
    logic       pwmG;
    logic       pwmB;
    logic       pwmW;
    logic       loadAck;
    logic       periodEnd;

    int tests = 0;
    int fails = 0;
    int printed = 0;
    int presc_mode = 0;

    // Reference model state: what the spec says the block holds after each edge.
    int m_cnt;
    bit m_prev;
    int m_pend[4];
    int m_act[4];
    bit m_flag;
    bit m_pwm[4];
    bit m_ack;
    bit m_pe;

    pwm_rgbw_gen dut (
        .clk(clk), .reset(reset), .clkPresc(clkPresc), .enable(enable), .load(load),
        .dutyR(dutyR), .dutyG(dutyG), .dutyB(dutyB), .dutyW(dutyW),
        .pwmR(pwmR), .pwmG(pwmG), .pwmB(pwmB), .pwmW(pwmW),
        .loadAck(loadAck), .periodEnd(periodEnd)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_step();
        int  d[4];
        bit  tick;
        bit  wrap;
        bit  apply;
        d[0] = int'(dutyR);
        d[1] = int'(dutyG);
        d[2] = int'(dutyB);
        d[3] = int'(dutyW);
        if (reset) begin
            m_cnt = 0; m_prev = 0; m_flag = 0; m_ack = 0; m_pe = 0;
            for (int i = 0; i < 4; i++) begin
                m_pend[i] = 0; m_act[i] = 0; m_pwm[i] = 0;
            end
        end else begin
            tick  = clkPresc && !m_prev;
            wrap  = tick && enable && (m_cnt == 255);
            apply = m_flag && (wrap || !enable);
            for (int i = 0; i < 4; i++) m_pwm[i] = enable && (m_cnt < m_act[i]);
            m_ack = apply;
            m_pe  = wrap;
            if (apply) for (int i = 0; i < 4; i++) m_act[i] = m_pend[i];
            if (load) begin
                for (int i = 0; i < 4; i++) m_pend[i] = d[i];
                m_flag = 1;
            end else if (apply) begin
                m_flag = 0;
            end
            m_cnt  = !enable ? 0 : (tick ? (m_cnt + 1) % 256 : m_cnt);
            m_prev = clkPresc;
        end
    endtask

    task automatic cycle();
        logic [5:0] got;
        logic [5:0] exp;
        @(posedge clk);
        #1;
        model_step();
        got = {pwmR, pwmG, pwmB, pwmW, loadAck, periodEnd};
        exp = {m_pwm[0], m_pwm[1], m_pwm[2], m_pwm[3], m_ack, m_pe};
        tests++;
        if (got !== exp) begin
            fails++;
            if (printed < 20) begin
                printed++;
                $display("FAIL model_cycle t=%0t {R,G,B,W,ack,pe} got=%b exp=%b", $time, got, exp);
            end
        end
        if (presc_mode == 0) clkPresc = ~clkPresc;
        else                 clkPresc = 1'($urandom_range(0, 1));
    endtask

    task automatic do_load(input int r, input int g, input int b, input int w);
        dutyR = 8'(r); dutyG = 8'(g); dutyB = 8'(b); dutyW = 8'(w);
        load = 1'b1;
        cycle();
        load = 1'b0;
    endtask

    task automatic wait_cnt(input int target, input string name);
        int n = 0;
        while (m_cnt != target && n < 1100) begin
            cycle();
            n++;
        end
        if (m_cnt != target) begin
            tests++; fails++;
            $display("FAIL %s_wait_cnt: reached %0d, required %0d", name, m_cnt, target);
        end
    endtask

    task automatic wait_ack(input string name, output int waited);
        waited = 0;
        do begin
            cycle();
            waited++;
        end while (loadAck !== 1'b1 && waited < 1100);
        tests++;
        if (loadAck !== 1'b1) begin
            fails++;
            $display("FAIL %s_ack_timeout: loadAck=%b after %0d clk, required 1", name, loadAck, waited);
        end
    endtask

    task automatic run_count(input int n, output int cr, output int cg, output int cb,
                             output int cw, output int ca);
        cr = 0; cg = 0; cb = 0; cw = 0; ca = 0;
        for (int k = 0; k < n; k++) begin
            cycle();
            cr += int'(pwmR); cg += int'(pwmG); cb += int'(pwmB); cw += int'(pwmW);
            ca += int'(loadAck);
        end
    endtask

    task automatic test_reset();
        int w;
        reset = 1'b1; enable = 1'b0; clkPresc = 1'b0; presc_mode = 0;
        dutyR = 8'h55; dutyG = 8'h55; dutyB = 8'h55; dutyW = 8'h55;
        load = 1'b1;
        cycle();
        cycle();
        load = 1'b0;
        tests++;
        if ({pwmR, pwmG, pwmB, pwmW, loadAck, periodEnd} !== 6'b000000) begin
            fails++;
            $display("FAIL reset_outputs: got=%b required=000000",
                     {pwmR, pwmG, pwmB, pwmW, loadAck, periodEnd});
        end
        reset = 1'b0;
        run_count(4, w, w, w, w, w);
        tests++;
        if (w !== 0) begin
            fails++;
            $display("FAIL reset_load_discarded: acks=%0d required 0", w);
        end
    endtask

    task automatic test_basic_duty();
        int waited, cr, cg, cb, cw, ca;
        enable = 1'b1;
        wait_cnt(10, "basic");
        do_load(64, 0, 0, 0);
        wait_ack("basic", waited);
        tests++;
        if (periodEnd !== 1'b1 || waited > 512) begin
            fails++;
            $display("FAIL basic_ack_at_wrap: periodEnd=%b waited=%0d, required 1 and <=512", periodEnd, waited);
        end
        run_count(511, cr, cg, cb, cw, ca);
        tests++;
        if (cr != 128 || cg != 0 || ca != 0) begin
            fails++;
            $display("FAIL basic_first_period: R=%0d G=%0d acks=%0d, required 128 0 0", cr, cg, ca);
        end
        run_count(512, cr, cg, cb, cw, ca);
        tests++;
        if (cr != 128) begin
            fails++;
            $display("FAIL basic_steady_period: R high=%0d, required 128", cr);
        end
    endtask

    task automatic test_extremes();
        int waited, cr, cg, cb, cw, ca;
        wait_cnt(5, "extremes");
        do_load(64, 0, 0, 255);
        wait_ack("extremes", waited);
        run_count(511, cr, cg, cb, cw, ca);
        tests++;
        if (cg != 0 || cw != 510 || cr != 128) begin
            fails++;
            $display("FAIL extremes_duty: G=%0d W=%0d R=%0d, required 0 510 128", cg, cw, cr);
        end
    endtask

    task automatic test_overwrite();
        int waited, cr, cg, cb, cw, ca;
        wait_cnt(5, "overwrite");
        do_load(8'h10, 0, 0, 255);
        cycle(); cycle(); cycle();
        do_load(8'h80, 0, 0, 255);
        wait_ack("overwrite", waited);
        run_count(511, cr, cg, cb, cw, ca);
        tests++;
        if (cr != 256 || ca != 0) begin
            fails++;
            $display("FAIL overwrite_last_wins: R high=%0d acks=%0d, required 256 0", cr, ca);
        end
    endtask

    task automatic test_load_on_wrap();
        int waited, n, cr, cg, cb, cw, ca;
        wait_cnt(5, "onwrap");
        do_load(8'h20, 0, 0, 0);
        n = 0;
        while (!(m_cnt == 255 && clkPresc == 1'b1 && m_prev == 1'b0) && n < 1100) begin
            cycle();
            n++;
        end
        do_load(8'h40, 0, 0, 0);
        tests++;
        if (loadAck !== 1'b1 || periodEnd !== 1'b1) begin
            fails++;
            $display("FAIL onwrap_first_ack: ack=%b pe=%b, required 1 1", loadAck, periodEnd);
        end
        run_count(511, cr, cg, cb, cw, ca);
        tests++;
        if (cr != 64 || ca != 0) begin
            fails++;
            $display("FAIL onwrap_old_active: R high=%0d acks=%0d, required 64 0", cr, ca);
        end
        cycle();
        tests++;
        if (loadAck !== 1'b1) begin
            fails++;
            $display("FAIL onwrap_second_ack: ack=%b, required 1", loadAck);
        end
        run_count(511, cr, cg, cb, cw, ca);
        tests++;
        if (cr != 128) begin
            fails++;
            $display("FAIL onwrap_new_active: R high=%0d, required 128", cr);
        end
    endtask

    task automatic test_enable_off();
        int cr, cg, cb, cw, ca;
        wait_cnt(77, "enoff");
        enable = 1'b0;
        do_load(8'h33, 0, 0, 0);
        tests++;
        if ({pwmR, pwmG, pwmB, pwmW, loadAck} !== 5'b00000) begin
            fails++;
            $display("FAIL enoff_outputs_low: got=%b required=00000", {pwmR, pwmG, pwmB, pwmW, loadAck});
        end
        cycle();
        tests++;
        if (loadAck !== 1'b1 || dut.cnt_q !== 8'd0) begin
            fails++;
            $display("FAIL enoff_ack_next_clk: ack=%b cnt=%0d, required 1 0", loadAck, dut.cnt_q);
        end
        enable = 1'b1;
        cycle();
        tests++;
        if (pwmR !== 1'b1) begin
            fails++;
            $display("FAIL enon_first_high: pwmR=%b, required 1", pwmR);
        end
        run_count(511, cr, cg, cb, cw, ca);
        tests++;
        if (cr != 101) begin
            fails++;
            $display("FAIL enon_duty_33: R high=%0d, required 101", cr);
        end
    endtask

    task automatic test_reset_mid();
        int cr, cg, cb, cw, ca;
        do_load(8'hff, 8'hff, 8'hff, 8'hff);
        wait_cnt(200, "rstmid");
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        tests++;
        if ({pwmR, pwmG, pwmB, pwmW, loadAck, periodEnd} !== 6'b000000 ||
            dut.cnt_q !== 8'd0 || dut.pend_flag_q !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_clear: outs=%b cnt=%0d flag=%b, required 000000 0 0",
                     {pwmR, pwmG, pwmB, pwmW, loadAck, periodEnd}, dut.cnt_q, dut.pend_flag_q);
        end
        run_count(600, cr, cg, cb, cw, ca);
        tests++;
        if (cr + cg + cb + cw + ca != 0) begin
            fails++;
            $display("FAIL rstmid_stays_low: highs=%0d acks=%0d, required 0 0", cr + cg + cb + cw, ca);
        end
    endtask

    task automatic test_random();
        presc_mode = 1;
        for (int k = 0; k < 4000; k++) begin
            enable = ($urandom_range(0, 15) != 0);
            reset  = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 7) == 0) begin
                dutyR = 8'($urandom); dutyG = 8'($urandom);
                dutyB = 8'($urandom); dutyW = 8'($urandom);
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            cycle();
        end
        load = 1'b0; reset = 1'b0; enable = 1'b1;
        presc_mode = 0;
    endtask

    initial begin
        test_reset();
        test_basic_duty();
        test_extremes();
        test_overwrite();
        test_load_on_wrap();
        test_enable_off();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pwm_rgbw_gen.md
PWM_RGBW_GEN -- requirements
Module: pwm_rgbw_gen

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock; all logic on its rising edge.
REQ-002 SHALL have ports: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports: clkPresc  input  1  prescaled clock level from the PWM clock divider, generated in the clk domain.
REQ-004 SHALL have ports: enable  input  1  high = PWM running; low = counter held, outputs low.
REQ-005 SHALL have ports: load  input  1  one-clk strobe; captures the four duty inputs.
REQ-006 SHALL have ports: dutyR, dutyG, dutyB, dutyW  input  8 each  requested duty, 0..255.
REQ-007 SHALL have ports: pwmR, pwmG, pwmB, pwmW  output  1 each  registered PWM outputs.
REQ-008 SHALL have ports: loadAck  output  1  one-clk pulse when pending duties become active.
REQ-009 SHALL have ports: periodEnd  output  1  one-clk pulse on each counter wrap.
REQ-010 SHALL use one clock; reset is synchronous and active-high, named clk and reset.

Function
REQ-011 SHALL register clkPresc into presc_d each clk; tick = clkPresc & ~presc_d (rising-edge detect, clk domain).
REQ-012 SHALL treat falling edges and static clkPresc as no tick.
REQ-013 SHALL keep an 8-bit period counter cnt; on tick with enable=1, cnt increments by 1 modulo 256 (255 -> 0).
REQ-014 SHALL hold cnt at 0 while enable=0; ticks are ignored.
REQ-015 SHALL keep 4x8-bit pending duty registers plus a pending flag; load=1 copies dutyR/G/B/W into pending and sets the flag on the same edge.
REQ-016 SHALL overwrite pending on repeated load before it is applied (last load wins; no ack for overwritten values).
REQ-017 SHALL apply pending to the 4x8-bit active duty registers on a wrap edge (tick, enable=1, cnt==255) when the flag is set; flag clears and loadAck pulses for that one clk.
REQ-018 SHALL apply pending on the next clk edge when enable=0 and flag set (no wrap needed); loadAck pulses likewise.
REQ-019 SHALL, when load coincides with an apply edge, apply the old pending contents, capture the new inputs into pending, and leave the flag set.
REQ-020 SHALL pulse periodEnd for one clk on each wrap edge, independent of the pending flag.
REQ-021 SHALL drive each pwmX <= (enable & (cnt < activeX)) each clk, unsigned 8-bit compare; output lags cnt by one clk.
REQ-022 SHALL produce: duty 0 -> output constantly low; duty N -> high for N of 256 counter steps; duty 255 -> high 255/256.
REQ-023 SHALL never glitch duty mid-period: active registers change only per REQ-017/REQ-018.
REQ-024 SHALL deassert all pwmX on the clk after enable falls.

Reset
REQ-025 SHALL on reset=1 at a clk edge clear cnt, presc_d, pending registers, pending flag, active registers, all pwmX, loadAck and periodEnd to 0.
REQ-026 SHALL give reset priority over load, tick and enable; load during reset is discarded.
REQ-027 SHALL count a clkPresc rising edge in the first clk after reset release as a tick, because presc_d resets to 0.

Verification
REQ-028 Bench: clkPresc toggles every clk (tick every 2 clk), enable=1, load dutyR=64 at cnt=10 -> loadAck at first wrap; pwmR high 64 ticks (128 clk) of each 512-clk period.
REQ-029 Bench: load dutyG=0 and dutyW=255 -> pwmG never high; pwmW low exactly 1 tick (2 clk) per period.
REQ-030 Bench: load 0x10 then 0x80 before the wrap -> a single loadAck; active=0x80; 0x10 never appears on the output.
REQ-031 Bench: load 0x40 on the exact wrap edge with 0x20 pending -> 0x20 active this period, flag still set; 0x40 active after the next wrap with a second loadAck.
REQ-032 Bench: enable=0 with load 0x33 -> outputs low, cnt=0, loadAck next clk; enable=1 -> pwm starts at cnt=0 with duty 0x33.
REQ-033 Bench: reset asserted mid-period with cnt=200 -> next clk: all outputs 0, cnt=0, flag=0; pwm stays low until a new load is applied.
